// File: rtl/maze_pkg.sv
// Shared definitions for the maze game core: keypad codes, game state
// encoding and the state-to-colour mapping used for VGA gating.
package maze_pkg;

    // Decoded keypad codes that the core reacts to; everything else is ignored.
    localparam logic [3:0] KEY_UP      = 4'h2;
    localparam logic [3:0] KEY_DOWN    = 4'h8;
    localparam logic [3:0] KEY_LEFT    = 4'h4;
    localparam logic [3:0] KEY_RIGHT   = 4'h6;
    localparam logic [3:0] KEY_RESTART = 4'hF;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WON  = 2'd1,
        ST_LOST = 2'd2
    } game_state_t;

    typedef struct packed {
        logic red;
        logic green;
        logic blue;
    } colour_t;

    // Exactly one colour is lit for every state; unused encodings fall back to blue.
    function automatic colour_t state_colour(input game_state_t s);
        colour_t c;
        c = '0;
        case (s)
            ST_WON:  c.green = 1'b1;
            ST_LOST: c.red   = 1'b1;
            default: c.blue  = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod_n.sv
// Modulo-N counter with enable and synchronous clear. wrap is high during
// the enabled cycle holding N-1, i.e. on the edge where the count rolls over.
module mod_n #(
    parameter int DW = 4,
    parameter int N  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam logic [DW-1:0] LAST = DW'(N - 1);

    logic [DW-1:0] count_q;

    assign wrap = en && (count_q == LAST);

    // Count while enabled, roll over at N-1, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr || wrap) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/maze_game_core.sv
// Maze game core: player position on a COLS x ROWS grid, step budget,
// collected keys and PLAY/WON/LOST status with timed auto-restart.
//
// Input handshake: key_valid_i is a one-cycle strobe with no back-pressure.
// Every cycle with key_valid_i high is a command; key_i is only looked at
// in that cycle. All outputs change on the edge that samples the strobe.
module maze_game_core
    import maze_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    parameter int AW        = $clog2(COLS * ROWS),
    parameter int MAX_STEPS = 20,
    parameter int N_KEYS    = 1,
    parameter logic [N_KEYS*AW-1:0] KEY_POS = '0,
    parameter int EXIT_POS  = COLS * ROWS - 1,
    parameter int START_POS = 0,
    parameter logic [COLS*ROWS-1:0] BLOCKED_MAP = '0,
    parameter int TIMEOUT_CYCLES = 75_000_000
) (
    input  logic                               clk_50MHz_i,
    input  logic                               rst_async_la_i,
    input  logic [3:0]                         key_i,
    input  logic                               key_valid_i,
    output logic [AW-1:0]                      pos_o,
    output logic [$clog2(MAX_STEPS+1)-1:0]     steps_o,
    output logic [N_KEYS-1:0]                  keys_o,
    output logic                               all_keys_o,
    output logic [1:0]                         state_o,
    output logic                               red_o,
    output logic                               green_o,
    output logic                               blue_o,
    output logic                               bump_o,
    output logic                               locked_o
);

    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] START_COL  = CW'(START_POS % COLS);
    localparam logic [RW-1:0] START_ROW  = RW'(START_POS / COLS);
    localparam logic [AW-1:0] EXIT_CELL  = AW'(EXIT_POS);
    localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);

    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [SW-1:0]     steps_q;
    logic [N_KEYS-1:0] keys_q;
    game_state_t       state_q;
    logic              bump_q;
    logic              locked_q;

    logic [RW-1:0]     t_row;
    logic [CW-1:0]     t_col;
    logic [AW-1:0]     t_pos;
    logic              is_move;
    logic              in_grid;
    logic              t_blocked;
    logic [N_KEYS-1:0] key_hit;
    logic [N_KEYS-1:0] keys_next;
    logic [SW-1:0]     steps_next;
    logic              playing;
    logic              move_ok;
    logic              bump_now;
    logic              at_exit;
    logic              win_now;
    logic              locked_now;
    logic              lose_now;
    logic              restart;
    logic              tmr_wrap;
    colour_t           colour;

    // Target cell from the registered row/col; edges never wrap.
    always_comb begin
        t_row   = row_q;
        t_col   = col_q;
        is_move = 1'b0;
        in_grid = 1'b1;
        case (key_i)
            KEY_UP: begin
                is_move = 1'b1;
                if (row_q == '0) in_grid = 1'b0;
                else             t_row   = row_q - 1'b1;
            end
            KEY_DOWN: begin
                is_move = 1'b1;
                if (row_q == ROW_LAST) in_grid = 1'b0;
                else                   t_row   = row_q + 1'b1;
            end
            KEY_LEFT: begin
                is_move = 1'b1;
                if (col_q == '0) in_grid = 1'b0;
                else             t_col   = col_q - 1'b1;
            end
            KEY_RIGHT: begin
                is_move = 1'b1;
                if (col_q == COL_LAST) in_grid = 1'b0;
                else                   t_col   = col_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign t_pos     = AW'(t_row) * AW'(COLS) + AW'(t_col);
    assign t_blocked = in_grid && BLOCKED_MAP[t_pos];

    // Every key whose cell matches the target is picked up together.
    always_comb begin
        key_hit = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            key_hit[i] = (t_pos == KEY_POS[i*AW +: AW]);
        end
    end

    assign playing    = (state_q == ST_PLAY);
    assign move_ok    = key_valid_i && playing && is_move && in_grid && !t_blocked;
    assign bump_now   = key_valid_i && playing && is_move && !(in_grid && !t_blocked);
    assign keys_next  = keys_q | key_hit;
    assign steps_next = steps_q + 1'b1;
    assign at_exit    = (t_pos == EXIT_CELL);
    // The key picked up on this very move counts towards opening the exit.
    assign win_now    = move_ok && at_exit && (&keys_next);
    assign locked_now = move_ok && at_exit && !(&keys_next);
    // Winning on the last step of the budget takes precedence over losing.
    assign lose_now   = move_ok && !win_now && (steps_next == STEP_LIMIT);
    // A restart strobe coinciding with timer expiry collapses into one restart.
    assign restart    = (key_valid_i && (key_i == KEY_RESTART)) || tmr_wrap;

    // End-screen hold timer, running only while WON or LOST.
    mod_n #(
        .DW (TW),
        .N  (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk_50MHz_i),
        .rst  (rst_async_la_i),
        .en   (!playing),
        .clr  (restart),
        .wrap (tmr_wrap)
    );

    // Game FSM plus position, step, key and pulse registers.
    always_ff @(posedge clk_50MHz_i or posedge rst_async_la_i) begin
        if (rst_async_la_i) begin
            row_q    <= START_ROW;
            col_q    <= START_COL;
            steps_q  <= '0;
            keys_q   <= '0;
            state_q  <= ST_PLAY;
            bump_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            bump_q   <= 1'b0;
            locked_q <= 1'b0;
            if (restart) begin
                row_q   <= START_ROW;
                col_q   <= START_COL;
                steps_q <= '0;
                keys_q  <= '0;
                state_q <= ST_PLAY;
            end else if (move_ok) begin
                row_q    <= t_row;
                col_q    <= t_col;
                steps_q  <= steps_next;
                keys_q   <= keys_next;
                locked_q <= locked_now;
                if (win_now) begin
                    state_q <= ST_WON;
                end else if (lose_now) begin
                    state_q <= ST_LOST;
                end
            end else if (bump_now) begin
                bump_q <= 1'b1;
            end
        end
    end

    assign colour     = state_colour(state_q);
    assign pos_o      = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign steps_o    = steps_q;
    assign keys_o     = keys_q;
    assign all_keys_o = &keys_q;
    assign state_o    = state_q;
    assign red_o      = colour.red;
    assign green_o    = colour.green;
    assign blue_o     = colour.blue;
    assign bump_o     = bump_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_maze_game_core.sv
// Directed bench for maze_game_core. Four instances with different
// parameter sets share clock and reset but have independent keypads:
//   A: defaults, key at cell 1, short timeout
//   B: wall on cell 1, key at cell 8
//   C: 4x3 grid, two keys (cells 1 and 10), budget 7
//   D: budget 3, short timeout
module tb_maze_game_core;

    logic       clk;
    logic       rst;
    logic [3:0] key_in [4];
    logic       key_vld [4];

    int checks;
    int errors;

    // A outputs (8x4, SW=5)
    logic [4:0] a_pos;  logic [4:0] a_steps; logic [0:0] a_keys; logic a_all;
    logic [1:0] a_state; logic a_r, a_g, a_b, a_bump, a_locked;
    // B outputs (8x4, SW=5)
    logic [4:0] b_pos;  logic [4:0] b_steps; logic [0:0] b_keys; logic b_all;
    logic [1:0] b_state; logic b_r, b_g, b_b, b_bump, b_locked;
    // C outputs (4x3, SW=3, 2 keys)
    logic [3:0] c_pos;  logic [2:0] c_steps; logic [1:0] c_keys; logic c_all;
    logic [1:0] c_state; logic c_r, c_g, c_b, c_bump, c_locked;
    // D outputs (8x4, SW=2)
    logic [4:0] d_pos;  logic [1:0] d_steps; logic [0:0] d_keys; logic d_all;
    logic [1:0] d_state; logic d_r, d_g, d_b, d_bump, d_locked;

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    maze_game_core #(.TIMEOUT_CYCLES(16), .KEY_POS(5'd1)) u_a (
        .clk_50MHz_i(clk), .rst_async_la_i(rst), .key_i(key_in[0]), .key_valid_i(key_vld[0]),
        .pos_o(a_pos), .steps_o(a_steps), .keys_o(a_keys), .all_keys_o(a_all), .state_o(a_state),
        .red_o(a_r), .green_o(a_g), .blue_o(a_b), .bump_o(a_bump), .locked_o(a_locked));

    maze_game_core #(.TIMEOUT_CYCLES(16), .KEY_POS(5'd8), .BLOCKED_MAP(32'h0000_0002)) u_b (
        .clk_50MHz_i(clk), .rst_async_la_i(rst), .key_i(key_in[1]), .key_valid_i(key_vld[1]),
        .pos_o(b_pos), .steps_o(b_steps), .keys_o(b_keys), .all_keys_o(b_all), .state_o(b_state),
        .red_o(b_r), .green_o(b_g), .blue_o(b_b), .bump_o(b_bump), .locked_o(b_locked));

    maze_game_core #(.COLS(4), .ROWS(3), .MAX_STEPS(7), .N_KEYS(2), .KEY_POS(8'hA1),
                     .TIMEOUT_CYCLES(16)) u_c (
        .clk_50MHz_i(clk), .rst_async_la_i(rst), .key_i(key_in[2]), .key_valid_i(key_vld[2]),
        .pos_o(c_pos), .steps_o(c_steps), .keys_o(c_keys), .all_keys_o(c_all), .state_o(c_state),
        .red_o(c_r), .green_o(c_g), .blue_o(c_b), .bump_o(c_bump), .locked_o(c_locked));

    maze_game_core #(.MAX_STEPS(3), .TIMEOUT_CYCLES(16)) u_d (
        .clk_50MHz_i(clk), .rst_async_la_i(rst), .key_i(key_in[3]), .key_valid_i(key_vld[3]),
        .pos_o(d_pos), .steps_o(d_steps), .keys_o(d_keys), .all_keys_o(d_all), .state_o(d_state),
        .red_o(d_r), .green_o(d_g), .blue_o(d_b), .bump_o(d_bump), .locked_o(d_locked));

    // comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: called at a negedge, strobes for one cycle, returns at the next
    // negedge with the result visible. Consecutive calls are back-to-back.
    task automatic press(input int d, input logic [3:0] code);
        key_in[d]  = code;
        key_vld[d] = 1'b1;
        @(negedge clk);
        key_vld[d] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            key_in[i]  = 4'h0;
            key_vld[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset values
        chk("a_rst_pos",    32'(a_pos),   32'd0);
        chk("a_rst_steps",  32'(a_steps), 32'd0);
        chk("a_rst_keys",   32'(a_keys),  32'd0);
        chk("a_rst_all",    32'(a_all),   32'd0);
        chk("a_rst_state",  32'(a_state), 32'd0);
        chk("a_rst_rgb",    32'({a_r, a_g, a_b}), 32'b001);
        chk("a_rst_pulses", 32'({a_bump, a_locked}), 32'd0);

        // A: three rights back-to-back, key at cell 1
        press(0, 4'h6);
        chk("a_r1_pos",  32'(a_pos),  32'd1);
        chk("a_r1_keys", 32'(a_keys), 32'd1);
        chk("a_r1_all",  32'(a_all),  32'd1);
        press(0, 4'h6);
        chk("a_r2_pos",  32'(a_pos),  32'd2);
        press(0, 4'h6);
        chk("a_r3_pos",   32'(a_pos),   32'd3);
        chk("a_r3_steps", 32'(a_steps), 32'd3);
        chk("a_r3_rgb",   32'({a_r, a_g, a_b}), 32'b001);

        // A: restart mid-game
        press(0, 4'hF);
        chk("a_f_pos",   32'(a_pos),   32'd0);
        chk("a_f_steps", 32'(a_steps), 32'd0);
        chk("a_f_keys",  32'(a_keys),  32'd0);
        chk("a_f_state", 32'(a_state), 32'd0);

        // A: bumps at the top-left corner, ignored code
        press(0, 4'h2);
        chk("a_up_bump",  32'(a_bump),  32'd1);
        chk("a_up_pos",   32'(a_pos),   32'd0);
        press(0, 4'h4);
        chk("a_lf_bump",  32'(a_bump),  32'd1);
        chk("a_lf_steps", 32'(a_steps), 32'd0);
        press(0, 4'h5);
        chk("a_ign_bump", 32'(a_bump),  32'd0);
        chk("a_ign_pos",  32'(a_pos),   32'd0);

        // A: down to the bottom row, then bump on the bottom edge
        press(0, 4'h8);
        chk("a_d1_pos",  32'(a_pos),  32'd8);
        chk("a_d1_bump", 32'(a_bump), 32'd0);
        press(0, 4'h8);
        press(0, 4'h8);
        chk("a_d3_pos",   32'(a_pos),   32'd24);
        chk("a_d3_steps", 32'(a_steps), 32'd3);
        press(0, 4'h8);
        chk("a_d4_bump", 32'(a_bump), 32'd1);
        chk("a_d4_pos",  32'(a_pos),  32'd24);

        // B: wall on cell 1, key at cell 8
        press(1, 4'h6);
        chk("b_wall_bump",  32'(b_bump),  32'd1);
        chk("b_wall_pos",   32'(b_pos),   32'd0);
        chk("b_wall_steps", 32'(b_steps), 32'd0);
        press(1, 4'h8);
        chk("b_key_pos",  32'(b_pos),  32'd8);
        chk("b_key_keys", 32'(b_keys), 32'd1);
        chk("b_key_all",  32'(b_all),  32'd1);
        chk("b_key_bump", 32'(b_bump), 32'd0);

        // C: two keys, exit locked first, win on last step
        press(2, 4'h6);
        chk("c_k0_keys", 32'(c_keys), 32'b01);
        chk("c_k0_all",  32'(c_all),  32'd0);
        press(2, 4'h6);
        press(2, 4'h6);
        press(2, 4'h8);
        chk("c_p7_pos", 32'(c_pos), 32'd7);
        press(2, 4'h8);
        chk("c_lock_pos",    32'(c_pos),    32'd11);
        chk("c_lock_pulse",  32'(c_locked), 32'd1);
        chk("c_lock_state",  32'(c_state),  32'd0);
        chk("c_lock_steps",  32'(c_steps),  32'd5);
        press(2, 4'h4);
        chk("c_k1_pos",    32'(c_pos),    32'd10);
        chk("c_k1_keys",   32'(c_keys),   32'b11);
        chk("c_k1_locked", 32'(c_locked), 32'd0);
        press(2, 4'h6);
        chk("c_win_state", 32'(c_state), 32'd1);
        chk("c_win_steps", 32'(c_steps), 32'd7);
        chk("c_win_rgb",   32'({c_r, c_g, c_b}), 32'b010);
        press(2, 4'h4);
        chk("c_won_ign_pos",  32'(c_pos),  32'd11);
        chk("c_won_ign_bump", 32'(c_bump), 32'd0);
        repeat (14) @(negedge clk);
        chk("c_hold_state", 32'(c_state), 32'd1);
        @(negedge clk);
        chk("c_to_state", 32'(c_state), 32'd0);
        chk("c_to_pos",   32'(c_pos),   32'd0);
        chk("c_to_steps", 32'(c_steps), 32'd0);
        chk("c_to_keys",  32'(c_keys),  32'd0);
        chk("c_to_rgb",   32'({c_r, c_g, c_b}), 32'b001);

        // D: budget of three steps, loss, restart coinciding with expiry
        press(3, 4'h6);
        press(3, 4'h6);
        chk("d_s2_state", 32'(d_state), 32'd0);
        press(3, 4'h6);
        chk("d_lost_state", 32'(d_state), 32'd2);
        chk("d_lost_steps", 32'(d_steps), 32'd3);
        chk("d_lost_rgb",   32'({d_r, d_g, d_b}), 32'b100);
        press(3, 4'h8);
        chk("d_ign_pos",  32'(d_pos),  32'd3);
        chk("d_ign_bump", 32'(d_bump), 32'd0);
        repeat (14) @(negedge clk);
        chk("d_hold_state", 32'(d_state), 32'd2);
        press(3, 4'hF);
        chk("d_rs_state", 32'(d_state), 32'd0);
        chk("d_rs_pos",   32'(d_pos),   32'd0);
        chk("d_rs_steps", 32'(d_steps), 32'd0);
        @(negedge clk);
        chk("d_rs2_state", 32'(d_state), 32'd0);
        press(3, 4'h6);
        chk("d_again_pos", 32'(d_pos), 32'd1);

        // A: asynchronous reset mid-game
        press(0, 4'h6);
        chk("a_pre_rst_pos", 32'(a_pos), 32'd25);
        #3 rst = 1'b1;
        #1;
        chk("a_arst_pos",   32'(a_pos),   32'd0);
        chk("a_arst_steps", 32'(a_steps), 32'd0);
        chk("d_arst_pos",   32'(d_pos),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_game_core.md
# maze_game_core

Parametrised game core: one block holds player position on a COLS×ROWS grid, the step budget, the collected-key set and the win/lose/timeout status. It accepts decoded keypad presses (4-bit code plus one-shot strobe) and drives position/step/key/status outputs to the character-RAM address, the 7-segment navigation display, the LEDs and the VGA colour gating. It generalises the single-key, fixed-size navigation plus status logic to any grid, any step budget, N keys, blocked cells and in-game restart.

## Interface

- COLS, 8: grid columns (≥2).
- ROWS, 4: grid rows (≥2).
- AW, $clog2(COLS*ROWS): position width (derived; do not override).
- MAX_STEPS, 20: step budget (≥1); SW = $clog2(MAX_STEPS+1).
- N_KEYS, 1: keys to collect before the exit opens (1–8).
- KEY_POS, 0: packed N_KEYS×AW cell indices; key i at [i*AW +: AW].
- EXIT_POS, COLS*ROWS-1: exit cell index.
- START_POS, 0: start cell index.
- BLOCKED_MAP, 0: COLS*ROWS-bit mask; bit c=1 marks cell c as a wall.
- TIMEOUT_CYCLES, 75_000_000: end-screen hold before auto-restart.

- clk_50MHz_i  in  1  system clock.
- rst_async_la_i  in  1  asynchronous reset, active-high.
- key_i  in  4  decoded keypad code.
- key_valid_i  in  1  one-cycle strobe; key_i sampled when high.
- pos_o  out  AW  cell index = row*COLS+col.
- steps_o  out  SW  steps used.
- keys_o  out  N_KEYS  collected-key bitmap.
- all_keys_o  out  1  &keys_o.
- state_o  out  2  PLAY=0, WON=1, LOST=2.
- red_o, green_o, blue_o  out  1 each  status colour.
- bump_o  out  1  one-cycle pulse on rejected move.
- locked_o  out  1  one-cycle pulse on entering exit without all keys.

## Operation

- Key codes: 2=up (row−1), 8=down (row+1), 4=left (col−1), 6=right (col+1), F=restart; all other codes ignored.
- Move, PLAY only: target computed from registered row/col. Target outside grid (no wrap) or BLOCKED_MAP[target]=1 → position and steps unchanged, bump_o pulses. Otherwise position ← target, steps_o +1.
- Key pickup: target equal to KEY_POS[i] sets keys_o[i] on the same edge as the move; set bits stay until restart. Several keys on one cell all set.
- Exit: target = EXIT_POS with all keys (including one picked up on this move) → WON. Without all keys → ordinary cell, locked_o pulses.
- Budget: valid move making steps_o = MAX_STEPS and not winning → LOST. Win beats lose on the same move.
- WON/LOST: moves ignored (no bump); a mod_n instance counts TIMEOUT_CYCLES, then auto-restart.
- Restart (code F any state, or timeout): position ← START_POS, steps_o ← 0, keys_o ← 0, state ← PLAY, timeout counter cleared.
- Colour: PLAY → blue; WON → green; LOST → red; exactly one high.

## Timing

- Reset: pos_o=START_POS, steps_o=0, keys_o=0, all_keys_o=(N_KEYS==0? n/a : 0), state_o=PLAY, blue_o=1, red_o=green_o=0, bump_o=locked_o=0, timeout counter 0.
- Latency: all outputs register-updated on the edge sampling key_valid_i; visible 1 cycle after strobe.
- Back-to-back strobes every cycle accepted; each sees the previous move's result.
- Timeout: first cycle of WON/LOST is count 0; restart takes effect on the edge after TIMEOUT_CYCLES−1 is reached (state held exactly TIMEOUT_CYCLES cycles).
- Restart strobe coincident with timeout expiry: single restart, identical result.
- Reset mid-game or mid-timeout: immediate return to reset values.

## Structure

- Package maze_pkg: key-code constants, state encoding, colour mapping function.
- Sub-module: reuse mod_n (DW = $clog2(TIMEOUT_CYCLES), N = TIMEOUT_CYCLES) for the end-screen timer, enabled only in WON/LOST, cleared on restart.
- Core: one registered row/col pair, step counter, key register, 3-state FSM; target/validity logic combinational.

## Test plan

- Defaults, reset, press 6 three times → pos_o 0→1→2→3, steps_o=3, blue_o=1.
- At pos 0 press 2 and 4 → bump_o pulses twice, pos_o=0, steps_o=0.
- BLOCKED_MAP bit 1 set, press 6 → bump_o, pos_o=0; KEY_POS=1 unblocked, press 6 → keys_o=1, all_keys_o=1.
- N_KEYS=2, enter EXIT_POS holding one key → locked_o pulse, state_o=PLAY; collect second key, re-enter exit → state_o=WON, green_o=1.
- MAX_STEPS=3, three valid non-exit moves → state_o=LOST, red_o=1; further presses ignored; after TIMEOUT_CYCLES (set 16) → pos_o=START_POS, steps_o=0, state_o=PLAY.
- Mid-game press F → full restart next cycle; last step landing on exit with all keys → WON, not LOST.
